// File: rtl/mac_if.sv
// Product-in / sum-out handshake bundle for mac_accumulator.
// master = producer/consumer side, slave = the accumulator.
interface mac_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;
  logic [CNT_W-1:0]  beat_count;

  modport master (
    output in_valid, product, in_last, out_ready,
    input  in_ready, out_valid, acc_out, overflow, beat_count
  );

  modport slave (
    input  in_valid, product, in_last, out_ready,
    output in_ready, out_valid, acc_out, overflow, beat_count
  );
endinterface

// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate back end: sums sign-extended products into a
// wider accumulator, flags signed overflow (sticky), optionally saturates,
// and holds the finished sum on a valid/ready port until it is taken.
module mac_accumulator #(
  parameter int PROD_W   = 64,
  parameter int ACC_W    = 72,
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  mac_if.slave  bus
);

  typedef enum logic {ACC, OUT} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ACC_W-1:0]  ext, sum;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ovf, ovf_nxt;
  logic              add_ovf;
  logic              accept;

  // Sign-extend the product up to accumulator width.
  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign ext = {{(ACC_W-PROD_W){bus.product[PROD_W-1]}}, bus.product};
    end else begin : g_noext
      assign ext = bus.product;
    end
  endgenerate

  assign accept  = bus.in_valid && (state == ACC);
  assign sum     = acc + ext;
  // Same-sign operands producing an opposite-sign result is a signed overflow.
  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  // State and datapath registers; async reset to an empty sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next state: accumulate in ACC, hold in OUT until taken; clear overrides all.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      ACC: begin
        if (accept) begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
          acc_nxt = sum;
          if (add_ovf) begin
            ovf_nxt = 1'b1;
            // Operand sign tells which rail we ran past.
            if (SATURATE) acc_nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
          end
          if (bus.in_last) state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = ACC;
    endcase
    if (clear) begin
      state_nxt = ACC;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end
  end

  // All outputs come straight from flops (state decode only).
  assign bus.in_ready   = (state == ACC);
  assign bus.out_valid  = (state == OUT);
  assign bus.acc_out    = acc;
  assign bus.overflow   = ovf;
  assign bus.beat_count = cnt;

endmodule
